audioport_control_unit: RTL and testbench
=========================================

# audioport_control_unit

APB-slave control and register block of the audioport. It holds the command, status, level, configuration and DSP coefficient registers and a word-addressed audio sample buffer. During playback it streams stereo 24-bit samples from the buffer to the datapath, one pair per `req_in` request. It raises an interrupt each time half of the buffer has been consumed.

## Interface
Parameters:
- `DUT_START_ADDRESS`, default 32'h8C00_0000: APB base address, word aligned.
- `DSP_REGISTERS`, default 4: number of 32-bit DSP coefficient registers.
- `ABUF_WORDS`, default 16: audio buffer size in 32-bit words. Must be even and ≥ 4.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `PSEL` in 1: APB select.
- `PENABLE` in 1: APB access phase.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in 32: byte address.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data.
- `PREADY` out 1: transfer ready.
- `PSLVERR` out 1: transfer error.
- `cfg_out` out 1: one-cycle pulse that loads configuration downstream.
- `cfg_reg_out` out 32: CFG_REG contents.
- `level_out` out 1: one-cycle pulse that loads the level downstream.
- `level_reg_out` out 32: LEVEL_REG contents.
- `dsp_regs_out` out DSP_REGISTERS*32: DSP register k is on bits [32k+31:32k].
- `clr_out` out 1: one-cycle pulse that clears the downstream datapath.
- `audio0_out` out 24: left sample.
- `audio1_out` out 24: right sample.
- `irq_out` out 1: interrupt, level-sensitive.
- `play_out` out 1: playback active.
- `tick_out` out 1: sample-consumed strobe.
- `req_in` in 1: datapath requests the next sample pair.

## Operation
Register map (word index i at `DUT_START_ADDRESS` + 4i):
- i=0: CMD_REG. Write only; reads return 0.
- i=1: STATUS_REG. Read only. Bit0 = `play_out`, bit1 = `irq_out`, all other bits 0.
- i=2: LEVEL_REG, read/write.
- i=3: CFG_REG, read/write.
- i=4 .. 4+DSP_REGISTERS-1: DSP_REGS, read/write.
- The next ABUF_WORDS words: ABUF, read/write.

Address decoding:
- Any address outside the map, or misaligned (PADDR[1:0] ≠ 0), is ignored on write and reads as 0.

APB behaviour:
- `PREADY` is always 1 (zero wait states). `PSLVERR` is always 0.
- A write commits at the rising edge where PSEL & PENABLE & PWRITE.
- `PRDATA` is combinational from `PADDR` while PSEL & !PWRITE, and is 0 otherwise.

CMD_REG values (a write whose value matches none of these is ignored):
- 1 START: sets play.
- 2 STOP: clears play and irq.
- 3 CLR: clears all ABUF words, the read pointer, irq, `audio0_out` and `audio1_out`, and pulses `clr_out`. Play is unchanged.
- 4 LEVEL: pulses `level_out`.
- 5 CFG: pulses `cfg_out`.
- 6 IRQACK: clears irq.

Playback:
- `tick_out` = `play_out` & `req_in` (combinational).
- On each tick edge:
  - `audio0_out` ← ABUF[rptr][23:0]
  - `audio1_out` ← ABUF[rptr+1][23:0]
  - rptr ← rptr+2, wrapping from ABUF_WORDS to 0.
- irq is set on a tick edge whose new rptr equals ABUF_WORDS/2 or 0. This means each half of the buffer has just been consumed.
- Ticks while irq is already set still advance the pointer (no stall).

Reset:
- All registers, ABUF, rptr, play and irq are 0.
- All outputs are 0, except `PREADY`, which is 1.

## Timing
- Command pulses (`cfg_out`, `level_out`, `clr_out`):
  - High for exactly the one cycle after the write edge.
  - Back-to-back command writes give back-to-back pulses.
- `play_out` and `irq_out` are registered and change on the edge of the causing write or tick.
- `cfg_reg_out`, `level_reg_out` and `dsp_regs_out` are registered and update on the write edge.
- `audio0_out` and `audio1_out` are valid one cycle after the tick cycle and hold until the next tick or CLR.

Simultaneous events (same cycle):
- STOP with tick: the tick is consumed (it uses the pre-edge play), then play clears.
- ABUF write with a tick reading the same word: audio gets the old value.
- IRQACK with an irq-set tick: set wins.
- STOP or CLR with an irq-set tick: clear wins.
- CLR with tick: CLR wins; audio = 0, rptr = 0.
- START while already playing: no effect.

Reset asserted mid-transfer or mid-playback: everything returns to the reset state immediately (asynchronously); the pending write is lost.

## Test plan
- Reset:
  - Read all register words → 0.
  - `PREADY`=1, `PSLVERR`=0, every other output 0.
- Register write/readback:
  - Write LEVEL=32'h0040_0040, CFG=32'h0000_0003, DSP0..3=32'h1..4.
  - Read back the same values; `dsp_regs_out`=128'h4_…_3_…_2_…_1 per the bit mapping.
  - Out-of-range and misaligned reads → 0.
- Commands:
  - CMD=5 → `cfg_out` high exactly 1 cycle.
  - CMD=4 → `level_out` 1 cycle.
  - CMD=7 → no pulse, no state change.
- Playback:
  - Fill ABUF[k]=32'hAB00_0000+k, CMD=1, then pulse `req_in` 8 times.
  - Audio pairs are (0,1),(2,3),…,(14,15), with the upper byte stripped.
  - `irq_out` rises after the 4th tick; IRQACK clears it; it rises again after the 8th tick.
  - The pointer then wraps to word 0.
- STATUS:
  - During playback with irq pending, read → 3.
  - CMD=2 → `play_out`=0, `irq_out`=0, `tick_out` stays 0 despite `req_in`=1.
- CLR:
  - With `play_out`=1 and rptr=6, CMD=3 → `clr_out` 1 cycle, ABUF reads 0, audio 0.
  - The next tick outputs words 0/1.
  - Assert `rst` mid-playback → immediate return to the reset state.

Source files
------------

// File: rtl/audioport_control_unit.sv
// APB register block of the audioport: command/status/level/config/DSP registers,
// a word-addressed sample buffer, and the playback pointer that feeds the datapath.
module audioport_control_unit #(
  parameter logic [31:0] DUT_START_ADDRESS = 32'h8C00_0000,
  parameter int          DSP_REGISTERS     = 4,
  parameter int          ABUF_WORDS        = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [31:0]                 PADDR,
  input  logic [31:0]                 PWDATA,
  output logic [31:0]                 PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
  output logic                        cfg_out,
  output logic [31:0]                 cfg_reg_out,
  output logic                        level_out,
  output logic [31:0]                 level_reg_out,
  output logic [DSP_REGISTERS*32-1:0] dsp_regs_out,
  output logic                        clr_out,
  output logic [23:0]                 audio0_out,
  output logic [23:0]                 audio1_out,
  output logic                        irq_out,
  output logic                        play_out,
  output logic                        tick_out,
  input  logic                        req_in
);

  localparam int AW        = $clog2(ABUF_WORDS);
  localparam int DW        = (DSP_REGISTERS > 1) ? $clog2(DSP_REGISTERS) : 1;
  localparam int MAP_WORDS = 4 + DSP_REGISTERS + ABUF_WORDS;
  localparam logic [29:0]   DSP_BASE  = 30'd4;
  localparam logic [29:0]   ABUF_BASE = 30'(4 + DSP_REGISTERS);
  localparam logic [AW-1:0] HALF      = AW'(ABUF_WORDS / 2);
  localparam logic [AW-1:0] LAST_PAIR = AW'(ABUF_WORDS - 2);

  logic [31:0]   dsp_regs [DSP_REGISTERS];
  logic [31:0]   abuf [ABUF_WORDS];
  logic [AW-1:0] rptr, rptr_p1, rptr_next;

  logic [29:0]   word_idx;
  logic          addr_ok, is_dsp, is_abuf, wr_en, tick, irq_set;
  logic [DW-1:0] dsp_sel;
  logic [AW-1:0] abuf_sel;
  logic          cmd_wr, cmd_start, cmd_stop, cmd_clr, cmd_level, cmd_cfg, cmd_ack;

  // Handshake: PREADY is held high, so every access phase (PSEL & PENABLE)
  // completes in its first cycle; writes commit on that edge, reads are combinational.
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;

  assign word_idx = PADDR[31:2] - DUT_START_ADDRESS[31:2];
  assign addr_ok  = (PADDR[1:0] == 2'b00) && (PADDR >= DUT_START_ADDRESS) &&
                    (word_idx < 30'(MAP_WORDS));
  assign is_dsp   = (word_idx >= DSP_BASE) && (word_idx < ABUF_BASE);
  assign is_abuf  = (word_idx >= ABUF_BASE);
  assign dsp_sel  = DW'(word_idx - DSP_BASE);
  assign abuf_sel = AW'(word_idx - ABUF_BASE);
  assign wr_en    = PSEL && PENABLE && PWRITE && addr_ok;

  assign cmd_wr    = wr_en && (word_idx == 30'd0);
  assign cmd_start = cmd_wr && (PWDATA == 32'd1);
  assign cmd_stop  = cmd_wr && (PWDATA == 32'd2);
  assign cmd_clr   = cmd_wr && (PWDATA == 32'd3);
  assign cmd_level = cmd_wr && (PWDATA == 32'd4);
  assign cmd_cfg   = cmd_wr && (PWDATA == 32'd5);
  assign cmd_ack   = cmd_wr && (PWDATA == 32'd6);

  assign tick      = play_out && req_in;
  assign tick_out  = tick;
  assign rptr_p1   = rptr + AW'(1);
  assign rptr_next = (rptr == LAST_PAIR) ? '0 : rptr + AW'(2);
  // A half of the buffer is fully consumed when the pointer lands on a half boundary.
  assign irq_set   = tick && ((rptr_next == HALF) || (rptr_next == '0));

  for (genvar k = 0; k < DSP_REGISTERS; k++) begin : g_dsp_out
    assign dsp_regs_out[32*k +: 32] = dsp_regs[k];
  end

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE && addr_ok) begin
      if (word_idx == 30'd1)      PRDATA = {30'b0, irq_out, play_out};
      else if (word_idx == 30'd2) PRDATA = level_reg_out;
      else if (word_idx == 30'd3) PRDATA = cfg_reg_out;
      else if (is_dsp)            PRDATA = dsp_regs[dsp_sel];
      else if (is_abuf)           PRDATA = abuf[abuf_sel];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_out       <= 1'b0;
      level_out     <= 1'b0;
      clr_out       <= 1'b0;
      play_out      <= 1'b0;
      irq_out       <= 1'b0;
      audio0_out    <= '0;
      audio1_out    <= '0;
      rptr          <= '0;
      level_reg_out <= '0;
      cfg_reg_out   <= '0;
      for (int k = 0; k < DSP_REGISTERS; k++) dsp_regs[k] <= '0;
      for (int k = 0; k < ABUF_WORDS; k++)    abuf[k]     <= '0;
    end else begin
      cfg_out   <= cmd_cfg;
      level_out <= cmd_level;
      clr_out   <= cmd_clr;

      if (cmd_start)     play_out <= 1'b1;
      else if (cmd_stop) play_out <= 1'b0;

      // Priority: STOP/CLR clear beats a tick set, which beats IRQACK.
      if (cmd_stop || cmd_clr) irq_out <= 1'b0;
      else if (irq_set)        irq_out <= 1'b1;
      else if (cmd_ack)        irq_out <= 1'b0;

      if (cmd_clr) begin
        audio0_out <= '0;
        audio1_out <= '0;
        rptr       <= '0;
        for (int k = 0; k < ABUF_WORDS; k++) abuf[k] <= '0;
      end else begin
        if (tick) begin
          audio0_out <= abuf[rptr][23:0];
          audio1_out <= abuf[rptr_p1][23:0];
          rptr       <= rptr_next;
        end
        if (wr_en && is_abuf) abuf[abuf_sel] <= PWDATA;
      end

      if (wr_en && (word_idx == 30'd2)) level_reg_out     <= PWDATA;
      if (wr_en && (word_idx == 30'd3)) cfg_reg_out       <= PWDATA;
      if (wr_en && is_dsp)              dsp_regs[dsp_sel] <= PWDATA;
    end
  end

endmodule

// File: tb/tb_audioport_control_unit.sv
// Bench for audioport_control_unit: directed test-plan sequence plus randomized
// APB/req traffic, all outputs compared every cycle against a buffer-level model.
module tb_audioport_control_unit;

  localparam logic [31:0] BASE = 32'h8C00_0000;
  localparam int D   = 4;
  localparam int N   = 16;
  localparam int MAP = 4 + D + N;

  logic          clk, rst;
  logic          PSEL, PENABLE, PWRITE;
  logic [31:0]   PADDR, PWDATA, PRDATA;
  logic          PREADY, PSLVERR;
  logic          cfg_out, level_out, clr_out;
  logic [31:0]   cfg_reg_out, level_reg_out;
  logic [D*32-1:0] dsp_regs_out;
  logic [23:0]   audio0_out, audio1_out;
  logic          irq_out, play_out, tick_out, req_in;

  audioport_control_unit #(
    .DUT_START_ADDRESS(BASE), .DSP_REGISTERS(D), .ABUF_WORDS(N)
  ) dut (
    .clk(clk), .rst(rst),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .cfg_out(cfg_out), .cfg_reg_out(cfg_reg_out),
    .level_out(level_out), .level_reg_out(level_reg_out),
    .dsp_regs_out(dsp_regs_out), .clr_out(clr_out),
    .audio0_out(audio0_out), .audio1_out(audio1_out),
    .irq_out(irq_out), .play_out(play_out), .tick_out(tick_out), .req_in(req_in)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  total = 0;
  int  bad   = 0;
  bit  chk_en  = 0;
  bit  rand_req = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic          m_play, m_irq, m_cfg_p, m_level_p, m_clr_p;
  int            m_rptr;
  logic [31:0]   m_level, m_cfg;
  logic [31:0]   m_dsp [D];
  logic [31:0]   m_abuf [N];
  logic [23:0]   m_a0, m_a1;
  logic [D*32-1:0] m_dsp_flat;

  function automatic int widx(input logic [31:0] a);
    logic [63:0] off;
    if (a[1:0] != 2'b00 || a < BASE) return -1;
    off = ({32'b0, a} - {32'b0, BASE}) >> 2;
    if (off >= 64'(MAP)) return -1;
    return int'(off);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    w = widx(a);
    if (w <= 0) return 32'h0;
    if (w == 1) return {30'b0, m_irq, m_play};
    if (w == 2) return m_level;
    if (w == 3) return m_cfg;
    if (w < 4 + D) return m_dsp[w - 4];
    return m_abuf[w - 4 - D];
  endfunction

  int          mw, m_np;
  logic [31:0] m_cmd;
  logic        m_tick, m_set;
  always_comb begin
    mw     = (PSEL && PENABLE && PWRITE) ? widx(PADDR) : -1;
    m_cmd  = (mw == 0) ? PWDATA : 32'h0;
    m_tick = m_play && req_in;
    m_np   = (m_rptr + 2) % N;
    m_set  = m_tick && (m_np % (N / 2) == 0);
    for (int k = 0; k < D; k++) m_dsp_flat[32*k +: 32] = m_dsp[k];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_play <= 0; m_irq <= 0; m_cfg_p <= 0; m_level_p <= 0; m_clr_p <= 0;
      m_rptr <= 0; m_level <= 0; m_cfg <= 0; m_a0 <= 0; m_a1 <= 0;
      foreach (m_dsp[k])  m_dsp[k]  <= 0;
      foreach (m_abuf[k]) m_abuf[k] <= 0;
    end else begin
      m_cfg_p   <= (m_cmd == 5);
      m_level_p <= (m_cmd == 4);
      m_clr_p   <= (m_cmd == 3);
      m_play    <= (m_cmd == 1) ? 1'b1 : (m_cmd == 2) ? 1'b0 : m_play;
      m_irq     <= (m_cmd == 2 || m_cmd == 3) ? 1'b0 : m_set ? 1'b1 :
                   (m_cmd == 6) ? 1'b0 : m_irq;
      if (m_cmd == 3) begin
        m_a0 <= 0; m_a1 <= 0; m_rptr <= 0;
        foreach (m_abuf[k]) m_abuf[k] <= 0;
      end else begin
        if (m_tick) begin
          m_a0   <= m_abuf[m_rptr][23:0];
          m_a1   <= m_abuf[m_rptr + 1][23:0];
          m_rptr <= m_np;
        end
        if (mw >= 4 + D) m_abuf[mw - 4 - D] <= PWDATA;
      end
      if (mw == 2) m_level <= PWDATA;
      if (mw == 3) m_cfg   <= PWDATA;
      if (mw >= 4 && mw < 4 + D) m_dsp[mw - 4] <= PWDATA;
    end
  end

  // scoreboard: every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      #1;
      check("m_play",  play_out,      m_play);
      check("m_irq",   irq_out,       m_irq);
      check("m_tick",  tick_out,      m_play & req_in);
      check("m_cfgp",  cfg_out,       m_cfg_p);
      check("m_lvlp",  level_out,     m_level_p);
      check("m_clrp",  clr_out,       m_clr_p);
      check("m_a0",    audio0_out,    m_a0);
      check("m_a1",    audio1_out,    m_a1);
      check("m_level", level_reg_out, m_level);
      check("m_cfg",   cfg_reg_out,   m_cfg);
      check("m_dsp",   dsp_regs_out,  m_dsp_flat);
      check("m_prdata", PRDATA, (PSEL && !PWRITE) ? model_read(PADDR) : 32'h0);
      check("m_ready", {PREADY, PSLVERR}, 2'b10);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] a(input int i);
    return BASE + 32'(4 * i);
  endfunction

  task automatic step();
    @(negedge clk);
    if (rand_req) req_in = ($urandom_range(0, 2) == 0);
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    step(); PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = addr; PWDATA = data;
    step(); PENABLE = 1;
    step(); PSEL = 0; PENABLE = 0; PWRITE = 0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    step(); PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = addr;
    step(); PENABLE = 1; #1 data = PRDATA;
    step(); PSEL = 0; PENABLE = 0;
  endtask

  task automatic pulse_req();
    step(); req_in = 1;
    step(); req_in = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    rst = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0; req_in = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", PREADY, 1'b1);
    check("rst_slverr", PSLVERR, 1'b0);
    check("rst_outs", {cfg_out, level_out, clr_out, irq_out, play_out, tick_out,
                       audio0_out, audio1_out}, '0);
    check("rst_regs", {cfg_reg_out, level_reg_out, dsp_regs_out}, '0);
    @(negedge clk); rst = 0; chk_en = 1;

    // reset readback of every word, plus holes
    for (int i = 0; i < MAP; i++) begin
      apb_read(a(i), rd); check("rst_read", rd, 32'h0);
    end

    // register write/readback
    apb_write(a(2), 32'h0040_0040);
    apb_write(a(3), 32'h0000_0003);
    for (int k = 0; k < D; k++) apb_write(a(4 + k), 32'(k + 1));
    apb_write(a(3) + 32'd1, 32'hDEAD_BEEF);
    apb_write(a(MAP), 32'hDEAD_BEEF);
    apb_read(a(2), rd); check("rb_level", rd, 32'h0040_0040);
    apb_read(a(3), rd); check("rb_cfg", rd, 32'h0000_0003);
    for (int k = 0; k < D; k++) begin
      apb_read(a(4 + k), rd); check("rb_dsp", rd, 32'(k + 1));
    end
    check("dsp_out", dsp_regs_out, 128'h00000004_00000003_00000002_00000001);
    apb_read(a(MAP), rd);          check("rd_oor", rd, 32'h0);
    apb_read(a(2) + 32'd2, rd);    check("rd_misal", rd, 32'h0);
    apb_read(BASE - 32'd4, rd);    check("rd_below", rd, 32'h0);
    apb_read(a(0), rd);            check("rd_cmd", rd, 32'h0);

    // command pulses
    apb_write(a(0), 32'd5); #1 check("cfg_pulse", cfg_out, 1'b1);
    check("cfg_nolvl", level_out, 1'b0);
    step(); #1 check("cfg_pulse_end", cfg_out, 1'b0);
    apb_write(a(0), 32'd4); #1 check("lvl_pulse", level_out, 1'b1);
    step(); #1 check("lvl_pulse_end", level_out, 1'b0);
    apb_write(a(0), 32'd7); #1
    check("cmd7_nopulse", {cfg_out, level_out, clr_out, play_out, irq_out}, 5'b0);

    // playback
    for (int k = 0; k < N; k++) apb_write(a(4 + D + k), 32'hAB00_0000 + 32'(k));
    apb_write(a(0), 32'd1); #1 check("play_on", play_out, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pulse_req(); #1;
      check("pb_a0", audio0_out, 24'(2 * i));
      check("pb_a1", audio1_out, 24'(2 * i + 1));
      check("pb_irq", irq_out, (i == 3 || i == 7));
      if (i == 3) begin
        apb_read(a(1), rd); check("status_3", rd, 32'd3);
        apb_write(a(0), 32'd6); #1 check("irqack", irq_out, 1'b0);
      end
    end
    pulse_req(); #1;
    check("wrap_a0", audio0_out, 24'd0);
    check("wrap_a1", audio1_out, 24'd1);
    apb_write(a(0), 32'd2); #1;
    check("stop", {play_out, irq_out}, 2'b00);
    req_in = 1; #1 check("stop_notick", tick_out, 1'b0);
    step(); req_in = 0;

    // CLR mid-playback at rptr=6
    apb_write(a(0), 32'd1);
    pulse_req(); pulse_req(); #1;
    check("pre_clr_a0", audio0_out, 24'd4);
    apb_write(a(0), 32'd3); #1;
    check("clr_pulse", clr_out, 1'b1);
    check("clr_audio", {audio0_out, audio1_out}, 48'h0);
    check("clr_play", play_out, 1'b1);
    step(); #1 check("clr_pulse_end", clr_out, 1'b0);
    apb_read(a(4 + D), rd);         check("clr_abuf0", rd, 32'h0);
    apb_read(a(4 + D + N - 1), rd); check("clr_abuf15", rd, 32'h0);
    apb_write(a(4 + D), 32'h1234_5678);
    apb_write(a(4 + D + 1), 32'hFF9A_BCDE);
    pulse_req(); #1;
    check("clr_next_a0", audio0_out, 24'h345678);
    check("clr_next_a1", audio1_out, 24'h9ABCDE);

    // randomized traffic
    rand_req = 1;
    repeat (400) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 2)
        apb_write(a(0), 32'($urandom_range(0, 7)));
      else if (op <= 5)
        apb_write(a($urandom_range(1, MAP + 1)) + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0),
                  $urandom);
      else
        apb_read(a($urandom_range(0, MAP + 1)), rd);
    end
    rand_req = 0; req_in = 0;

    // reset mid-playback and mid-transfer
    apb_write(a(0), 32'd1);
    apb_write(a(2), 32'h0000_1234);
    pulse_req();
    step(); PSEL = 1; PWRITE = 1; PENABLE = 1; PADDR = a(3); PWDATA = 32'h5555_AAAA;
    #3 rst = 1;
    #1;
    check("arst_play", {play_out, irq_out}, 2'b00);
    check("arst_audio", {audio0_out, audio1_out}, 48'h0);
    check("arst_regs", {level_reg_out, cfg_reg_out}, 64'h0);
    check("arst_ready", PREADY, 1'b1);
    step(); PSEL = 0; PENABLE = 0; PWRITE = 0;
    step(); rst = 0;
    apb_read(a(3), rd); check("arst_lost_wr", rd, 32'h0);
    apb_read(a(2), rd); check("arst_level", rd, 32'h0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
